// File: rtl/addr_reader_pkg.sv
// Shared defaults and width helpers for the address stream reader and its return FIFO.
package addr_reader_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_RD_LAT     = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  // Width able to hold every value 0..depth (credit and occupancy counters).
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer width for a depth-entry ring; a single-entry ring still needs one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/addr_stream_reader_if.sv
// Bus bundle for addr_stream_reader: address input stream, memory read port, data output stream.
interface addr_stream_reader_if
  import addr_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
);
  localparam int CNT_W = cnt_w(FIFO_DEPTH);

  // Streams use valid/ready: a transfer happens on a rising edge where both are high;
  // the producer holds valid and payload stable until that edge, ready may change freely.
  logic              addr_valid;
  logic [ADDR_W-1:0] addr;
  logic              addr_ready;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  // Debug view of the credit counter (in-flight reads + buffered words).
  logic [CNT_W-1:0]  outstanding;

  modport slave (
    input  addr_valid, addr, mem_rd_data, out_ready,
    output addr_ready, mem_rd_en, mem_addr, out_valid, out_data, outstanding
  );

  modport master (
    output addr_valid, addr, mem_rd_data, out_ready,
    input  addr_ready, mem_rd_en, mem_addr, out_valid, out_data, outstanding
  );

endinterface

// File: rtl/addr_reader_fifo.sv
// First-word-fall-through return buffer; depth need not be a power of two.
module addr_reader_fifo
  import addr_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  localparam int CNT_W = cnt_w(DEPTH),
  localparam int PTR_W = ptr_w(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign rd_data = mem[rd_ptr];

  // A push into a full FIFO is still legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/addr_stream_reader.sv
// Reads one word per accepted address from a fixed-latency memory and returns the words
// in order; a credit counter reserves a buffer slot for every read before it is issued.
module addr_stream_reader
  import addr_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  addr_stream_reader_if.slave  bus
);

  localparam int               CNT_W   = cnt_w(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CREDITS = CNT_W'(FIFO_DEPTH);

  logic [CNT_W-1:0]  outstanding;
  logic [RD_LAT-1:0] ret_pipe;
  logic              accept;
  logic              pop;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;

  // Ready depends only on the registered credit count (and reset), never on out_ready.
  assign bus.addr_ready  = !rst && (outstanding < CREDITS);
  assign accept          = bus.addr_valid && bus.addr_ready;
  assign bus.mem_rd_en   = accept;
  assign bus.mem_addr    = bus.addr;

  assign bus.out_valid   = !fifo_empty;
  assign bus.out_data    = fifo_head;
  assign pop             = bus.out_valid && bus.out_ready && !rst;
  assign bus.outstanding = outstanding;

  // The last stage marks the cycle in which mem_rd_data belongs to an issued read.
  assign fifo_push = ret_pipe[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      ret_pipe <= '0;
    end else begin
      ret_pipe[0] <= accept;
      for (int i = 1; i < RD_LAT; i++) begin
        ret_pipe[i] <= ret_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  addr_reader_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (bus.mem_rd_data),
    .pop     (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Credits make a write into a full buffer impossible; the counter must equal
  // the number of reads still in the pipe plus the words already buffered.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full));

  a_credit_balance : assert property (@(posedge clk) disable iff (rst)
    int'(outstanding) == $countones(ret_pipe) + int'(fifo_count));

endmodule

// File: tb/tb_addr_stream_reader.sv
// Directed bench for addr_stream_reader: default build (RD_LAT=2, depth 4) plus RD_LAT=1, depth 3.
module tb_addr_stream_reader;
  import addr_reader_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LAT_A = 2;
  localparam int DEP_A = 4;
  localparam int LAT_B = 1;
  localparam int DEP_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  addr_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEP_A)) bus_a ();
  addr_stream_reader_if #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEP_B)) bus_b ();

  addr_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_A), .FIFO_DEPTH(DEP_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  addr_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT_B), .FIFO_DEPTH(DEP_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'hA5A5_0000 ^ a;
  endfunction

  // ---------------- memory models: word for an address appears RD_LAT cycles later ----------------
  logic [AW-1:0] mem_pipe_a [LAT_A] = '{default: '0};
  logic [AW-1:0] mem_pipe_b [LAT_B] = '{default: '0};

  always @(posedge clk) begin
    mem_pipe_a[0] <= bus_a.mem_addr;
    for (int i = 1; i < LAT_A; i++) mem_pipe_a[i] <= mem_pipe_a[i-1];
    mem_pipe_b[0] <= bus_b.mem_addr;
  end

  assign bus_a.mem_rd_data = mem_word(mem_pipe_a[LAT_A-1]);
  assign bus_b.mem_rd_data = mem_word(mem_pipe_b[LAT_B-1]);

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_a[$];
  logic [DW-1:0] exp_b[$];
  int got_a = 0;
  int got_b = 0;

  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (rst) begin
      exp_a.delete();
      exp_b.delete();
    end else begin
      if (bus_a.out_valid && bus_a.out_ready) begin
        checks++;
        got_a++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL sb_a_extra got %h required no word", bus_a.out_data);
        end else begin
          e = exp_a.pop_front();
          if (bus_a.out_data !== e) begin
            errors++;
            $display("FAIL sb_a_data got %h required %h", bus_a.out_data, e);
          end
        end
      end
      if (bus_a.addr_valid && bus_a.addr_ready) exp_a.push_back(mem_word(bus_a.addr));
      if (bus_b.out_valid && bus_b.out_ready) begin
        checks++;
        got_b++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL sb_b_extra got %h required no word", bus_b.out_data);
        end else begin
          e = exp_b.pop_front();
          if (bus_b.out_data !== e) begin
            errors++;
            $display("FAIL sb_b_data got %h required %h", bus_b.out_data, e);
          end
        end
      end
      if (bus_b.addr_valid && bus_b.addr_ready) exp_b.push_back(mem_word(bus_b.addr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.addr_valid = 1'b1; bus_a.addr = 32'h55; bus_a.out_ready = 1'b1;
    bus_b.addr_valid = 1'b1; bus_b.addr = 32'h66; bus_b.out_ready = 1'b1;
    repeat (3) tick();
    #1;
    checks++; if (bus_a.addr_ready !== 1'b0) begin errors++; $display("FAIL rst_a_ready got %b required 0", bus_a.addr_ready); end
    checks++; if (bus_a.mem_rd_en !== 1'b0) begin errors++; $display("FAIL rst_a_rd_en got %b required 0", bus_a.mem_rd_en); end
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_out_valid got %b required 0", bus_a.out_valid); end
    checks++; if (bus_b.addr_ready !== 1'b0) begin errors++; $display("FAIL rst_b_ready got %b required 0", bus_b.addr_ready); end
    tick();
    rst = 1'b0;
    bus_a.addr_valid = 1'b0;
    bus_b.addr_valid = 1'b0;
    #1;
    checks++; if (bus_a.addr_ready !== 1'b1) begin errors++; $display("FAIL rel_a_ready got %b required 1", bus_a.addr_ready); end
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL rel_a_out_valid got %b required 0", bus_a.out_valid); end
    checks++; if (bus_a.outstanding !== '0) begin errors++; $display("FAIL rel_a_outstanding got %0d required 0", bus_a.outstanding); end
    checks++; if (bus_b.addr_ready !== 1'b1) begin errors++; $display("FAIL rel_b_ready got %b required 1", bus_b.addr_ready); end
    checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL rel_b_out_valid got %b required 0", bus_b.out_valid); end
  endtask

  task automatic test_single();
    tick();
    bus_a.out_ready = 1'b1;
    bus_a.addr_valid = 1'b1;
    bus_a.addr = 32'h10;
    #1;
    checks++; if (bus_a.mem_rd_en !== 1'b1) begin errors++; $display("FAIL single_rd_en got %b required 1", bus_a.mem_rd_en); end
    checks++; if (bus_a.mem_addr !== 32'h10) begin errors++; $display("FAIL single_mem_addr got %h required 00000010", bus_a.mem_addr); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus_a.addr_valid = 1'b0;
      #1;
      checks++; if (bus_a.mem_rd_en !== 1'b0) begin errors++; $display("FAIL single_rd_en_c%0d got %b required 0", k, bus_a.mem_rd_en); end
      checks++; if (bus_a.out_valid !== (k == 3)) begin errors++; $display("FAIL single_out_valid_c%0d got %b required %b", k, bus_a.out_valid, (k == 3)); end
      if (k == 3) begin
        checks++; if (bus_a.out_data !== 32'hA5A5_0010) begin errors++; $display("FAIL single_out_data got %h required a5a50010", bus_a.out_data); end
      end
      if (k == 4) begin
        checks++; if (bus_a.outstanding !== '0) begin errors++; $display("FAIL single_credit_back got %0d required 0", bus_a.outstanding); end
      end
    end
  endtask

  task automatic test_stream();
    int got0;
    got0 = got_a;
    bus_a.out_ready = 1'b1;
    for (int k = 0; k < 22; k++) begin
      tick();
      bus_a.addr_valid = (k < 16);
      bus_a.addr = 32'(k);
      #1;
      if (k < 16) begin
        checks++; if (bus_a.addr_ready !== 1'b1) begin errors++; $display("FAIL stream_ready_c%0d got %b required 1", k, bus_a.addr_ready); end
      end
      checks++; if (bus_a.out_valid !== (k >= 3 && k < 19)) begin errors++; $display("FAIL stream_out_valid_c%0d got %b required %b", k, bus_a.out_valid, (k >= 3 && k < 19)); end
      if (k >= 3 && k < 19) begin
        checks++; if (bus_a.out_data !== mem_word(32'(k - 3))) begin errors++; $display("FAIL stream_data_c%0d got %h required %h", k, bus_a.out_data, mem_word(32'(k - 3))); end
      end
    end
    bus_a.addr_valid = 1'b0;
    checks++; if (got_a - got0 != 16) begin errors++; $display("FAIL stream_count got %0d required 16", got_a - got0); end
  endtask

  task automatic test_backpressure();
    int acc;
    int got0;
    acc = 0;
    got0 = got_a;
    bus_a.out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      bus_a.addr_valid = 1'b1;
      bus_a.addr = 32'h100 + 32'(acc) * 32'd4;
      #1;
      checks++; if (bus_a.addr_ready !== (k < 4)) begin errors++; $display("FAIL bp_ready_c%0d got %b required %b", k, bus_a.addr_ready, (k < 4)); end
      if (bus_a.addr_ready) acc++;
    end
    checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepts got %0d required 4", acc); end
    for (int k = 10; k < 40; k++) begin
      tick();
      bus_a.out_ready = 1'b1;
      bus_a.addr_valid = (acc < 8);
      bus_a.addr = 32'h100 + 32'(acc) * 32'd4;
      #1;
      if (k == 10) begin
        checks++; if (bus_a.addr_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_ready got %b required 0", bus_a.addr_ready); end
        checks++; if (bus_a.out_data !== 32'hA5A5_0100) begin errors++; $display("FAIL bp_head got %h required a5a50100", bus_a.out_data); end
      end
      if (k == 11) begin
        checks++; if (bus_a.addr_ready !== 1'b1) begin errors++; $display("FAIL bp_resume_ready got %b required 1", bus_a.addr_ready); end
      end
      if (bus_a.addr_valid && bus_a.addr_ready) acc++;
    end
    bus_a.addr_valid = 1'b0;
    checks++; if (got_a - got0 != 8) begin errors++; $display("FAIL bp_words got %0d required 8", got_a - got0); end
    checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL bp_leftover got %0d required 0", exp_a.size()); end
  endtask

  task automatic test_full_toggle();
    int acc;
    int got0;
    acc = 0;
    got0 = got_a;
    for (int k = 0; k < 70; k++) begin
      tick();
      bus_a.out_ready = k[0];
      bus_a.addr_valid = (acc < 20);
      bus_a.addr = 32'h400 + 32'(acc);
      #1;
      checks++; if (int'(bus_a.outstanding) > DEP_A) begin errors++; $display("FAIL toggle_credit_c%0d got %0d required <= 4", k, bus_a.outstanding); end
      if (bus_a.addr_valid && bus_a.addr_ready) acc++;
    end
    bus_a.addr_valid = 1'b0;
    checks++; if (got_a - got0 != 20) begin errors++; $display("FAIL toggle_words got %0d required 20", got_a - got0); end
    checks++; if (exp_a.size() != 0) begin errors++; $display("FAIL toggle_leftover got %0d required 0", exp_a.size()); end
  endtask

  task automatic test_reset_mid();
    tick();
    bus_a.out_ready = 1'b0;
    bus_a.addr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus_a.addr = 32'h200 + 32'(k) * 32'd4;
      #1;
      checks++; if (bus_a.addr_ready !== 1'b1) begin errors++; $display("FAIL mid_accept_c%0d got %b required 1", k, bus_a.addr_ready); end
      tick();
    end
    bus_a.addr_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL mid_buffered got %b required 1", bus_a.out_valid); end
    checks++; if (bus_a.outstanding !== 3'd3) begin errors++; $display("FAIL mid_outstanding got %0d required 3", bus_a.outstanding); end
    tick();
    rst = 1'b0;
    for (int k = 4; k < 7; k++) begin
      #1;
      checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid_c%0d got %b required 0", k, bus_a.out_valid); end
      checks++; if (bus_a.addr_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_c%0d got %b required 1", k, bus_a.addr_ready); end
      checks++; if (bus_a.outstanding !== '0) begin errors++; $display("FAIL mid_credit_c%0d got %0d required 0", k, bus_a.outstanding); end
      tick();
    end
    bus_a.out_ready = 1'b1;
    bus_a.addr_valid = 1'b1;
    bus_a.addr = 32'h300;
    #1;
    checks++; if (bus_a.mem_rd_en !== 1'b1) begin errors++; $display("FAIL mid_new_rd_en got %b required 1", bus_a.mem_rd_en); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus_a.addr_valid = 1'b0;
      #1;
      checks++; if (bus_a.out_valid !== (k == 3)) begin errors++; $display("FAIL mid_new_valid_c%0d got %b required %b", k, bus_a.out_valid, (k == 3)); end
    end
    checks++; if (bus_a.out_data !== 32'hA5A5_0300) begin errors++; $display("FAIL mid_new_data got %h required a5a50300", bus_a.out_data); end
    tick();
  endtask

  task automatic test_sweep();
    int acc;
    int got0;
    logic [AW-1:0] next_addr;
    acc = 0;
    got0 = got_b;
    next_addr = $urandom();
    for (int k = 0; k < 400 && (acc < 50 || exp_b.size() != 0); k++) begin
      tick();
      bus_b.addr_valid = (acc < 50);
      bus_b.addr = next_addr;
      bus_b.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (acc < 50 && k >= 2) begin
        checks++; if (bus_b.out_valid !== 1'b1) begin errors++; $display("FAIL sweep_throughput_c%0d got %b required 1", k, bus_b.out_valid); end
      end
      if (bus_b.addr_valid && bus_b.addr_ready) begin
        acc++;
        next_addr = $urandom();
      end
    end
    bus_b.addr_valid = 1'b0;
    bus_b.out_ready = 1'b0;
    checks++; if (got_b - got0 != 50) begin errors++; $display("FAIL sweep_words got %0d required 50", got_b - got0); end
    checks++; if (exp_b.size() != 0) begin errors++; $display("FAIL sweep_leftover got %0d required 0", exp_b.size()); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus_a.addr_valid = 1'b0; bus_a.addr = '0; bus_a.out_ready = 1'b0;
    bus_b.addr_valid = 1'b0; bus_b.addr = '0; bus_b.out_ready = 1'b0;
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_full_toggle();
    test_reset_mid();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached with %0d errors", errors);
    $fatal(1, "watchdog");
  end

endmodule
